reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL expose ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; low freezes all state.
- iROB_clr  in  1  mispredict flush.
- iDC_en  in  1  dispatch valid.
- iDC_pc  in  32  instruction PC.
- iDC_op  in  6  decoded op.
- iDC_imm  in  32  immediate.
- iDC_rd_nick  in  4  destination ROB tag.
- iDC_rs1_rdy  in  1  rs1 value valid.
- iDC_rs1_nick  in  4  rs1 ROB tag.
- iDC_rs1_dt  in  32  rs1 value.
- iDC_rs2_rdy  in  1  rs2 value valid.
- iDC_rs2_nick  in  4  rs2 ROB tag.
- iDC_rs2_dt  in  32  rs2 value.
- iEX_en  in  1  ALU CDB valid.
- iEX_nick  in  4  ALU CDB tag.
- iEX_dt  in  32  ALU CDB data.
- iLSB_en  in  1  load CDB valid.
- iLSB_nick  in  4  load CDB tag.
- iLSB_dt  in  32  load CDB data.
- oRS_full  out  1  dispatch stall.
- oRS_en  out  1  issue valid to execute.
- oRS_pc  out  32  issued PC.
- oRS_op  out  6  issued op.
- oRS_imm  out  32  issued immediate.
- oRS_rd_nick  out  4  issued destination tag.
- oRS_rs1_dt  out  32  issued rs1 value.
- oRS_rs2_dt  out  32  issued rs2 value.

REQ-002 SHALL use parameter RS_SIZE, default 16, meaning the number of entries.

Function
REQ-003 SHALL hold RS_SIZE entries, each containing: valid, pc, op, imm, rd_nick, and for each of rs1/rs2 a rdy flag, a nick and data.
REQ-004 SHALL write the dispatch into the lowest-index free entry at the clk edge when iDC_en=1, rdy=1 and a free entry exists.
REQ-005 SHALL silently drop a dispatch when no free entry exists; upstream honouring oRS_full makes this unreachable.
REQ-006 SHALL drive oRS_full combinationally high when valid count >= RS_SIZE-1, giving one cycle of lookahead.
REQ-007 SHALL wake operands: for each valid entry whose operand has rdy=0 and nick equal to a broadcasting CDB tag (iEX or iLSB), set rdy=1 and capture that CDB's data at the edge.
REQ-008 SHALL apply CDB matching to the dispatch in flight: an operand dispatched with rdy=0 whose nick matches a same-cycle broadcast is stored with rdy=1 and the CDB data.
REQ-009 SHALL treat equal iEX and iLSB tags as impossible; if they occur, iEX wins.
REQ-010 SHALL select from registered entry state only: an entry is ready when valid and both operand rdy flags are set; a same-edge wake makes the entry eligible the next cycle.
REQ-011 SHALL, when any entry is ready, register the selected entry's fields onto oRS_* with oRS_en=1 and clear that entry's valid at the same edge.
REQ-012 SHALL register oRS_en=0 when no entry is ready; oRS_* data fields hold their previous values.
REQ-013 SHALL issue at most one entry per cycle; minimum latency is dispatch edge N to oRS_en high after edge N+1.
REQ-014 SHALL allow the entry freed by an issue to be reused by a dispatch on the same edge only from the next cycle onward; a same-edge dispatch uses a different free entry.
REQ-015 SHALL, on iROB_clr=1 with rdy=1, clear all valid bits and oRS_en at the edge, with priority over dispatch, wake and issue.
REQ-016 SHALL hold all state and outputs unchanged when rdy=0, including oRS_en.

Reset
REQ-017 SHALL on rst: clear all valid bits, set oRS_en=0 and set oRS_pc/op/imm/rd_nick/rs1_dt/rs2_dt to 0; oRS_full is then 0.
REQ-018 SHALL give rst priority over rdy, iROB_clr and all other inputs, and SHALL discard any in-flight dispatch or wake on a reset edge.

Configuration
REQ-019 SHALL define the macro RS_OLDEST_FIRST_EN with the following behaviour:
- Defined: each entry carries an age stamp from a 4-bit dispatch counter, and select picks the oldest ready entry by wrap-aware comparison.
- Undefined: select picks the lowest-index ready entry, and no age storage exists.

Structure
REQ-020 SHALL take the bus widths (AddrBus, OpBus, ImmBus, NickBus, DataBus) and RS_SIZE from the shared config package.
REQ-021 SHALL implement the free-slot finder and the ready selector as one sub-module, rs_select, a priority encoder returning index plus hit.

Verification
REQ-022 SHALL pass these directed scenarios:
- Dispatch ADD with both operands ready (rs1=5, rs2=7, rd_nick=3) -> oRS_en=1 after the second edge with rs1_dt=5, rs2_dt=7, rd_nick=3.
- Dispatch with rs1_rdy=0 nick=9; two cycles later iEX_en nick=9 dt=0x1234 -> issue one cycle later with oRS_rs1_dt=0x1234.
- Dispatch with rs2 nick=4 unready in the same cycle as iLSB_en nick=4 dt=0xFF -> entry stored ready, issues next cycle with rs2_dt=0xFF.
- Fill 15 entries, none ready -> oRS_full=1; issue one -> oRS_full drops the following cycle.
- With 8 ready entries, iROB_clr pulse -> oRS_en=0 next cycle and oRS_full=0; no further issue.
- With RS_OLDEST_FIRST_EN defined, dispatch A into slot 2 then B into slot 0, both ready -> A issues before B; with it undefined, B issues first.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared bus widths, entry layout and age comparison for the reservation station.
package reservation_station_pkg;
    localparam int AddrBus = 32;
    localparam int OpBus   = 6;
    localparam int ImmBus  = 32;
    localparam int NickBus = 4;
    localparam int DataBus = 32;
    localparam int RsSize  = 16;
    localparam int AgeBus  = 4;

    typedef struct packed {
        logic               rdy;
        logic [NickBus-1:0] nick;
        logic [DataBus-1:0] dt;
    } opnd_t;

    typedef struct packed {
        logic               valid;
        logic [AddrBus-1:0] pc;
        logic [OpBus-1:0]   op;
        logic [ImmBus-1:0]  imm;
        logic [NickBus-1:0] rd_nick;
        opnd_t              rs1;
        opnd_t              rs2;
    } rs_entry_t;

    // a is older than b when a-b is negative modulo the counter width
    function automatic logic age_older(input logic [AgeBus-1:0] a, input logic [AgeBus-1:0] b);
        logic [AgeBus-1:0] d;
        d = a - b;
        return d[AgeBus-1];
    endfunction
endpackage

// File: rtl/reservation_station_select.sv
// Lowest-index priority encoder; used both as free-slot finder and ready selector.
module rs_select #(
    parameter int N = 16,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          hit
);
    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
                hit = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reservation_station.sv
// Reservation station: dispatch into free slots, CDB wakeup, single-issue select.
// Optional macro RS_OLDEST_FIRST_EN selects the oldest ready entry instead of the lowest index.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE = RsSize
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               iROB_clr,
    input  logic               iDC_en,
    input  logic [AddrBus-1:0] iDC_pc,
    input  logic [OpBus-1:0]   iDC_op,
    input  logic [ImmBus-1:0]  iDC_imm,
    input  logic [NickBus-1:0] iDC_rd_nick,
    input  logic               iDC_rs1_rdy,
    input  logic [NickBus-1:0] iDC_rs1_nick,
    input  logic [DataBus-1:0] iDC_rs1_dt,
    input  logic               iDC_rs2_rdy,
    input  logic [NickBus-1:0] iDC_rs2_nick,
    input  logic [DataBus-1:0] iDC_rs2_dt,
    input  logic               iEX_en,
    input  logic [NickBus-1:0] iEX_nick,
    input  logic [DataBus-1:0] iEX_dt,
    input  logic               iLSB_en,
    input  logic [NickBus-1:0] iLSB_nick,
    input  logic [DataBus-1:0] iLSB_dt,
    output logic               oRS_full,
    output logic               oRS_en,
    output logic [AddrBus-1:0] oRS_pc,
    output logic [OpBus-1:0]   oRS_op,
    output logic [ImmBus-1:0]  oRS_imm,
    output logic [NickBus-1:0] oRS_rd_nick,
    output logic [DataBus-1:0] oRS_rs1_dt,
    output logic [DataBus-1:0] oRS_rs2_dt
);
    localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int CW = $clog2(RS_SIZE + 1);

    rs_entry_t          ent [RS_SIZE];
    rs_entry_t          dc_ent;
    logic [RS_SIZE-1:0] valid_vec, ready_vec, pick_vec;
    logic [IW-1:0]      free_idx, sel_idx;
    logic               free_hit, sel_hit;
    logic [CW-1:0]      cnt;

    // iEX has priority over iLSB if both carry the same tag
    function automatic opnd_t snoop(input opnd_t o);
        opnd_t r;
        r = o;
        if (!o.rdy) begin
            if (iEX_en && iEX_nick == o.nick) begin
                r.rdy = 1'b1;
                r.dt  = iEX_dt;
            end else if (iLSB_en && iLSB_nick == o.nick) begin
                r.rdy = 1'b1;
                r.dt  = iLSB_dt;
            end
        end
        return r;
    endfunction

    always_comb begin
        cnt = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            valid_vec[i] = ent[i].valid;
            ready_vec[i] = ent[i].valid && ent[i].rs1.rdy && ent[i].rs2.rdy;
            cnt          = cnt + CW'(ent[i].valid);
        end
    end

    assign oRS_full = (cnt >= CW'(RS_SIZE - 1));

    always_comb begin
        dc_ent         = '0;
        dc_ent.valid   = 1'b1;
        dc_ent.pc      = iDC_pc;
        dc_ent.op      = iDC_op;
        dc_ent.imm     = iDC_imm;
        dc_ent.rd_nick = iDC_rd_nick;
        dc_ent.rs1     = snoop({iDC_rs1_rdy, iDC_rs1_nick, iDC_rs1_dt});
        dc_ent.rs2     = snoop({iDC_rs2_rdy, iDC_rs2_nick, iDC_rs2_dt});
    end

`ifdef RS_OLDEST_FIRST_EN
    logic [AgeBus-1:0]  age [RS_SIZE];
    logic [AgeBus-1:0]  age_cnt;
    logic [RS_SIZE-1:0] oldest_vec;

    // Non-transitive wrap compare can leave no winner; fall back to plain ready set.
    always_comb begin
        oldest_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready_vec[i]) begin
                oldest_vec[i] = 1'b1;
                for (int j = 0; j < RS_SIZE; j++)
                    if (j != i && ready_vec[j] && age_older(age[j], age[i]))
                        oldest_vec[i] = 1'b0;
            end
        end
        pick_vec = (oldest_vec != '0) ? oldest_vec : ready_vec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            age_cnt <= '0;
        end else if (rdy && !iROB_clr && iDC_en && free_hit) begin
            age[free_idx] <= age_cnt;
            age_cnt       <= age_cnt + 1'b1;
        end
    end
`else
    assign pick_vec = ready_vec;
`endif

    rs_select #(.N(RS_SIZE)) u_free (.req(~valid_vec), .idx(free_idx), .hit(free_hit));
    rs_select #(.N(RS_SIZE)) u_sel  (.req(pick_vec),   .idx(sel_idx),  .hit(sel_hit));

    // free_idx comes from registered valid, so it never aliases the slot issuing this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) ent[i].valid <= 1'b0;
            oRS_en      <= 1'b0;
            oRS_pc      <= '0;
            oRS_op      <= '0;
            oRS_imm     <= '0;
            oRS_rd_nick <= '0;
            oRS_rs1_dt  <= '0;
            oRS_rs2_dt  <= '0;
        end else if (rdy) begin
            if (iROB_clr) begin
                for (int i = 0; i < RS_SIZE; i++) ent[i].valid <= 1'b0;
                oRS_en <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (ent[i].valid) begin
                        ent[i].rs1 <= snoop(ent[i].rs1);
                        ent[i].rs2 <= snoop(ent[i].rs2);
                    end
                end
                oRS_en <= sel_hit;
                if (sel_hit) begin
                    oRS_pc              <= ent[sel_idx].pc;
                    oRS_op              <= ent[sel_idx].op;
                    oRS_imm             <= ent[sel_idx].imm;
                    oRS_rd_nick         <= ent[sel_idx].rd_nick;
                    oRS_rs1_dt          <= ent[sel_idx].rs1.dt;
                    oRS_rs2_dt          <= ent[sel_idx].rs2.dt;
                    ent[sel_idx].valid  <= 1'b0;
                end
                if (iDC_en && free_hit)
                    ent[free_idx] <= dc_ent;
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station; expectations follow RS_OLDEST_FIRST_EN if defined.
module tb_reservation_station;
    logic        clk = 1'b0;
    logic        rst, rdy, iROB_clr;
    logic        iDC_en;
    logic [31:0] iDC_pc;
    logic [5:0]  iDC_op;
    logic [31:0] iDC_imm;
    logic [3:0]  iDC_rd_nick;
    logic        iDC_rs1_rdy, iDC_rs2_rdy;
    logic [3:0]  iDC_rs1_nick, iDC_rs2_nick;
    logic [31:0] iDC_rs1_dt, iDC_rs2_dt;
    logic        iEX_en, iLSB_en;
    logic [3:0]  iEX_nick, iLSB_nick;
    logic [31:0] iEX_dt, iLSB_dt;
    logic        oRS_full, oRS_en;
    logic [31:0] oRS_pc, oRS_imm, oRS_rs1_dt, oRS_rs2_dt;
    logic [5:0]  oRS_op;
    logic [3:0]  oRS_rd_nick;

    int n_chk = 0;
    int n_err = 0;

    reservation_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .iROB_clr(iROB_clr),
        .iDC_en(iDC_en), .iDC_pc(iDC_pc), .iDC_op(iDC_op), .iDC_imm(iDC_imm),
        .iDC_rd_nick(iDC_rd_nick),
        .iDC_rs1_rdy(iDC_rs1_rdy), .iDC_rs1_nick(iDC_rs1_nick), .iDC_rs1_dt(iDC_rs1_dt),
        .iDC_rs2_rdy(iDC_rs2_rdy), .iDC_rs2_nick(iDC_rs2_nick), .iDC_rs2_dt(iDC_rs2_dt),
        .iEX_en(iEX_en), .iEX_nick(iEX_nick), .iEX_dt(iEX_dt),
        .iLSB_en(iLSB_en), .iLSB_nick(iLSB_nick), .iLSB_dt(iLSB_dt),
        .oRS_full(oRS_full), .oRS_en(oRS_en), .oRS_pc(oRS_pc), .oRS_op(oRS_op),
        .oRS_imm(oRS_imm), .oRS_rd_nick(oRS_rd_nick),
        .oRS_rs1_dt(oRS_rs1_dt), .oRS_rs2_dt(oRS_rs2_dt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [31:0] pc, input logic [3:0] rd,
                            input logic r1rdy, input logic [3:0] r1nick, input logic [31:0] r1dt,
                            input logic r2rdy, input logic [3:0] r2nick, input logic [31:0] r2dt);
        iDC_en = 1'b1; iDC_pc = pc; iDC_op = 6'h01; iDC_imm = pc + 32'h10; iDC_rd_nick = rd;
        iDC_rs1_rdy = r1rdy; iDC_rs1_nick = r1nick; iDC_rs1_dt = r1dt;
        iDC_rs2_rdy = r2rdy; iDC_rs2_nick = r2nick; iDC_rs2_dt = r2dt;
        step();
        iDC_en = 1'b0;
    endtask

    task automatic ex_bcast(input logic [3:0] nick, input logic [31:0] dt);
        iEX_en = 1'b1; iEX_nick = nick; iEX_dt = dt;
        step();
        iEX_en = 1'b0;
    endtask

    task automatic flush();
        iROB_clr = 1'b1;
        step();
        iROB_clr = 1'b0;
    endtask

    logic [31:0] first_pc, second_pc;

    initial begin
        rst = 1'b1; rdy = 1'b1; iROB_clr = 1'b0; iDC_en = 1'b0;
        iDC_pc = '0; iDC_op = '0; iDC_imm = '0; iDC_rd_nick = '0;
        iDC_rs1_rdy = 1'b0; iDC_rs1_nick = '0; iDC_rs1_dt = '0;
        iDC_rs2_rdy = 1'b0; iDC_rs2_nick = '0; iDC_rs2_dt = '0;
        iEX_en = 1'b0; iEX_nick = '0; iEX_dt = '0;
        iLSB_en = 1'b0; iLSB_nick = '0; iLSB_dt = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_en", 32'(oRS_en), 32'd0);
        chk("rst_pc", oRS_pc, 32'd0);
        chk("rst_full", 32'(oRS_full), 32'd0);

        // both operands ready
        dispatch(32'h100, 4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7);
        chk("s1_en_n", 32'(oRS_en), 32'd0);
        step();
        chk("s1_en", 32'(oRS_en), 32'd1);
        chk("s1_rs1", oRS_rs1_dt, 32'd5);
        chk("s1_rs2", oRS_rs2_dt, 32'd7);
        chk("s1_rd", 32'(oRS_rd_nick), 32'd3);
        chk("s1_imm", oRS_imm, 32'h110);
        rdy = 1'b0;
        step();
        chk("frz_en", 32'(oRS_en), 32'd1);
        rdy = 1'b1;
        step();
        chk("s1_en_off", 32'(oRS_en), 32'd0);

        // rs1 woken by iEX two cycles after dispatch
        dispatch(32'h200, 4'd2, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'd2);
        step();
        chk("s2_wait", 32'(oRS_en), 32'd0);
        ex_bcast(4'd9, 32'h1234);
        chk("s2_wake", 32'(oRS_en), 32'd0);
        step();
        chk("s2_en", 32'(oRS_en), 32'd1);
        chk("s2_rs1", oRS_rs1_dt, 32'h1234);
        chk("s2_pc", oRS_pc, 32'h200);

        // same-cycle iLSB capture on dispatch
        iLSB_en = 1'b1; iLSB_nick = 4'd4; iLSB_dt = 32'hFF;
        dispatch(32'h300, 4'd1, 1'b1, 4'd0, 32'd1, 1'b0, 4'd4, 32'd0);
        iLSB_en = 1'b0;
        step();
        chk("s3_en", 32'(oRS_en), 32'd1);
        chk("s3_rs2", oRS_rs2_dt, 32'hFF);
        step();
        chk("s3_idle", 32'(oRS_en), 32'd0);

        // fill 15 waiting entries
        for (int k = 0; k < 15; k++) begin
            dispatch(32'h1000 + 32'(k * 4), 4'(k), 1'b0, 4'(k), 32'd0, 1'b1, 4'd0, 32'd0);
            if (k == 13) chk("s4_full14", 32'(oRS_full), 32'd0);
        end
        chk("s4_full15", 32'(oRS_full), 32'd1);
        ex_bcast(4'd5, 32'h55);
        chk("s4_full_wk", 32'(oRS_full), 32'd1);
        step();
        chk("s4_en", 32'(oRS_en), 32'd1);
        chk("s4_pc", oRS_pc, 32'h1014);
        chk("s4_full_drop", 32'(oRS_full), 32'd0);
        flush();

        // 8 ready entries then flush
        for (int k = 0; k < 8; k++)
            dispatch(32'h2000 + 32'(k * 4), 4'd0, 1'b0, 4'd6, 32'd0, 1'b1, 4'd0, 32'd0);
        ex_bcast(4'd6, 32'h66);
        step();
        chk("s5_en", 32'(oRS_en), 32'd1);
        chk("s5_pc", oRS_pc, 32'h2000);
        flush();
        chk("s5_clr_en", 32'(oRS_en), 32'd0);
        chk("s5_clr_full", 32'(oRS_full), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("s5_quiet", 32'(oRS_en), 32'd0);
        end

        // A in slot 2, B later in slot 0
        dispatch(32'h3000, 4'd0, 1'b0, 4'd10, 32'd0, 1'b1, 4'd0, 32'd0);
        dispatch(32'h3100, 4'd0, 1'b0, 4'd11, 32'd0, 1'b1, 4'd0, 32'd0);
        dispatch(32'hA00,  4'd0, 1'b0, 4'd12, 32'd0, 1'b1, 4'd0, 32'd0);
        ex_bcast(4'd10, 32'h10);
        step();
        chk("s6_x0", oRS_pc, 32'h3000);
        dispatch(32'hB00, 4'd0, 1'b0, 4'd12, 32'd0, 1'b1, 4'd0, 32'd0);
        ex_bcast(4'd12, 32'h12);
`ifdef RS_OLDEST_FIRST_EN
        first_pc = 32'hA00; second_pc = 32'hB00;
`else
        first_pc = 32'hB00; second_pc = 32'hA00;
`endif
        step();
        chk("s6_first_en", 32'(oRS_en), 32'd1);
        chk("s6_first", oRS_pc, first_pc);
        step();
        chk("s6_second", oRS_pc, second_pc);
        step();
        chk("s6_done", 32'(oRS_en), 32'd0);
        flush();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
